// File: rtl/risc16_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : risc16_imem_loader
//  Description : Boot-time program loader for the RiSC-16 core. It receives a
//                framed byte stream over a valid/ready handshake and packs the
//                bytes into 16-bit instruction words. Each word is written to
//                instruction memory in order, starting at address 0. The core
//                is held in reset until a whole frame has loaded and its
//                checksum matches.
//  Frame       : LEN_HI, LEN_LO (word count N), N x {WORD_HI, WORD_LO}, CHK
//                All fields are big-endian. CHK is the XOR of the 2N payload
//                bytes.
//  Ports       :
//    clk          in   rising-edge clock
//    reset_n      in   asynchronous active-low reset
//    start        in   1-cycle pulse, begins a frame (IDLE/RUN/ERROR only)
//    in_valid     in   byte-stream valid
//    in_data      in   byte-stream data [7:0]
//    in_ready     out  loader accepts in_data this cycle
//    imem_we      out  instruction-memory write strobe, 1 cycle per word
//    imem_addr    out  write address [ADDR_W-1:0]
//    imem_wdata   out  write data [15:0]
//    core_reset   out  active-high reset to the core (registered)
//    done         out  frame loaded, checksum OK, core released
//    error        out  frame rejected (checksum mismatch or oversize)
//  Revision    : 1.0  initial release
// ============================================================================
module risc16_imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    // The counter only has to reach DEPTH, because a larger N is refused
    // before any payload byte is taken.
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CHECK   = 3'd5,
        S_RUN     = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        len;
    logic [7:0]         hi_byte;
    logic [CNT_W-1:0]   count;
    logic [7:0]         chk;
    logic               xfer;
    logic [15:0]        len_full;
    logic               last_word;

    assign xfer      = in_valid && in_ready;
    // In LEN_LO the low byte is still on the bus, so N is formed from it here.
    assign len_full  = {len[15:8], in_data};
    // count holds the index of the word now being received.
    assign last_word = ((16'(count) + 16'd1) == len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (xfer) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if ({1'b0, len_full} > 17'(DEPTH)) state_next = S_ERROR;
                    else if (len_full == 16'd0)        state_next = S_CHECK;
                    else                               state_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                in_ready = 1'b1;
                if (xfer) state_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                in_ready = 1'b1;
                if (xfer) state_next = last_word ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                in_ready = 1'b1;
                if (xfer) state_next = (in_data == chk) ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                if (start) state_next = S_LEN_HI;
            end
            S_ERROR: begin
                if (start) state_next = S_LEN_HI;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so that core_reset
    // only changes on a clock edge and is never a decode glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            core_reset <= (state_next != S_RUN);
            done       <= (state_next == S_RUN);
            error      <= (state_next == S_ERROR);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len        <= 16'd0;
            hi_byte    <= 8'd0;
            count      <= '0;
            chk        <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) begin
                        count     <= '0;
                        chk       <= 8'd0;
                        imem_addr <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) len[15:8] <= in_data;
                end
                S_LEN_LO: begin
                    if (xfer) len[7:0] <= in_data;
                end
                S_DATA_HI: begin
                    if (xfer) begin
                        hi_byte <= in_data;
                        chk     <= chk ^ in_data;
                    end
                end
                S_DATA_LO: begin
                    // The write is issued one cycle after the low byte
                    // arrives, using the index captured at that moment.
                    if (xfer) begin
                        chk        <= chk ^ in_data;
                        imem_we    <= 1'b1;
                        imem_wdata <= {hi_byte, in_data};
                        imem_addr  <= ADDR_W'(count);
                        count      <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_risc16_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc16_imem_loader
//  Description : Self-checking bench for risc16_imem_loader. A per-cycle vector
//                table covers the basic frames. Hand-written sequences cover
//                stalled transfers and reset during a frame.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_risc16_imem_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    risc16_imem_loader #(.DEPTH(256), .ADDR_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        vl;
        logic [7:0]  data;
        logic        rdy;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        dn;
        logic        er;
        logic        cr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic vl, input logic [7:0] data,
                       input logic rdy, input logic we, input logic [15:0] addr,
                       input logic [15:0] wd, input logic dn, input logic er,
                       input logic cr);
        vec_t v;
        v.st = st; v.vl = vl; v.data = data; v.rdy = rdy; v.we = we;
        v.addr = addr; v.wd = wd; v.dn = dn; v.er = er; v.cr = cr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: logs {addr, data} for every strobe and checks that each
    // strobe lasts a single cycle.
    logic [31:0] wr_q[$];
    logic        prev_we = 1'b0;
    always @(negedge clk) begin
        if (imem_we) begin
            wr_q.push_back({imem_addr, imem_wdata});
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_width: got 2+ cycle strobe, expected 1 (t=%0t)", $time);
            end
        end
        prev_we = imem_we;
    end

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Present one byte until it is accepted. in_valid is random at 'duty'
    // percent. A transfer happens on the next rising edge when valid and
    // ready are both high at the falling edge.
    task automatic send_byte(input logic [7:0] b, input int duty);
        logic sent;
        sent = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            in_valid = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            in_data  = b;
            if (in_valid && in_ready) begin
                sent = 1'b1;
                break;
            end
        end
        if (!sent) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got no transfer, expected byte %h accepted", b);
        end
    endtask

    task automatic send_frame1(input int duty);
        logic [7:0] fr [7];
        fr = '{8'h00, 8'h02, 8'hE0, 8'h81, 8'hA4, 8'h02, 8'hC7};
        for (int i = 0; i < 7; i++) send_byte(fr[i], duty);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done_and_check(input string tag);
        for (int k = 0; k < 20 && !done; k++) @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd0);
        check({tag, "_nwrites"}, wr_q.size(), 32'd2);
        if (wr_q.size() == 2) begin
            check({tag, "_wr0"}, wr_q[0], 32'h0000_E081);
            check({tag, "_wr1"}, wr_q[1], 32'h0001_A402);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // ---- table: scenarios 1-4 -------------------------------------
        //   st vl data   rdy we addr     wdata    dn er cr
        // frame 1, good checksum, one stall cycle
        add(1, 0, 8'h00, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 1, 8'h00, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 1, 8'h02, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 0, 8'hFF, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 1, 8'hE0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 1, 8'h81, 1, 1, 16'h0000, 16'hE081, 0, 0, 1);
        add(0, 1, 8'hA4, 1, 0, 16'h0000, 16'hE081, 0, 0, 1);
        add(0, 1, 8'h02, 1, 1, 16'h0001, 16'hA402, 0, 0, 1);
        add(0, 1, 8'hC7, 0, 0, 16'h0001, 16'hA402, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 16'h0001, 16'hA402, 1, 0, 0);
        // frame 1 again, bad checksum; start mid-frame is ignored
        add(1, 0, 8'h00, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h00, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h02, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(1, 1, 8'hE0, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h81, 1, 1, 16'h0000, 16'hE081, 0, 0, 1);
        add(0, 1, 8'hA4, 1, 0, 16'h0000, 16'hE081, 0, 0, 1);
        add(0, 1, 8'h02, 1, 1, 16'h0001, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h00, 0, 0, 16'h0001, 16'hA402, 0, 1, 1);
        // oversize length 257
        add(1, 0, 8'h00, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h01, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h01, 0, 0, 16'h0000, 16'hA402, 0, 1, 1);
        add(0, 1, 8'h00, 0, 0, 16'h0000, 16'hA402, 0, 1, 1);
        // empty frame, CHK=00 -> RUN
        add(1, 0, 8'h00, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h00, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h00, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h00, 0, 0, 16'h0000, 16'hA402, 1, 0, 0);
        // empty frame, CHK=5A -> ERROR
        add(1, 0, 8'h00, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h00, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h00, 1, 0, 16'h0000, 16'hA402, 0, 0, 1);
        add(0, 1, 8'h5A, 0, 0, 16'h0000, 16'hA402, 0, 1, 1);

        // ---- reset values ---------------------------------------------
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", {16'd0, imem_addr}, 32'd0);
        check("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        check("idle_core_reset", {31'd0, core_reset}, 32'd1);

        // ---- table-driven run -----------------------------------------
        foreach (vecs[i]) begin
            @(negedge clk);
            start    = vecs[i].st;
            in_valid = vecs[i].vl;
            in_data  = vecs[i].data;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
            check($sformatf("v%0d_imem_we", i), {31'd0, imem_we}, {31'd0, vecs[i].we});
            check($sformatf("v%0d_imem_addr", i), {16'd0, imem_addr}, {16'd0, vecs[i].addr});
            check($sformatf("v%0d_imem_wdata", i), {16'd0, imem_wdata}, {16'd0, vecs[i].wd});
            check($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vecs[i].dn});
            check($sformatf("v%0d_error", i), {31'd0, error}, {31'd0, vecs[i].er});
            check($sformatf("v%0d_core_reset", i), {31'd0, core_reset}, {31'd0, vecs[i].cr});
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;

        // ---- scenario 5: frame 1 with 30% valid duty ------------------
        wr_q.delete();
        pulse_start();
        send_frame1(30);
        wait_done_and_check("stall");

        // ---- scenario 6: reset after the first word ------------------
        pulse_start();
        wr_q.delete();
        send_byte(8'h00, 100);
        send_byte(8'h02, 100);
        send_byte(8'hE0, 100);
        send_byte(8'h81, 100);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("abort_first_write", wr_q.size(), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_core_reset", {31'd0, core_reset}, 32'd1);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_imem_we", {31'd0, imem_we}, 32'd0);
        check("abort_imem_addr", {16'd0, imem_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("abort_held_in_ready", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b1;
        wr_q.delete();
        pulse_start();
        send_frame1(100);
        wait_done_and_check("reload");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
